// File: rtl/ast_arb_pkg.sv
// Shared types and elaboration checks for the Avalon-ST packet arbiter.
package ast_arb_pkg;

    // Two-state arbitration FSM: waiting for a SOP, or a packet owns the output.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int NUM_SRC_MIN = 32'sd2;
    localparam int NUM_SRC_MAX = 32'sd8;

    // True when the requester count is inside the supported range.
    function automatic logic num_src_is_legal(input int n);
        return (n >= NUM_SRC_MIN) && (n <= NUM_SRC_MAX);
    endfunction

endpackage

// File: rtl/ast_packet_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_SRC  = 2,
    parameter int ID_WIDTH = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_last_grant,
    output logic [NUM_SRC-1:0]  o_grant,
    output logic [ID_WIDTH-1:0] o_grant_idx,
    output logic                o_grant_valid
);

    int                  w_pos;
    logic [ID_WIDTH-1:0] w_idx;

    // Scan sources in rotation order starting one past the previous winner.
    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_pos         = 0;
        w_idx         = '0;
        for (int off = 1; off <= NUM_SRC; off++) begin
            w_pos = (int'(i_last_grant) + off) % NUM_SRC;
            w_idx = w_pos[ID_WIDTH-1:0];
            if (!o_grant_valid && i_req[w_idx]) begin
                o_grant_valid  = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end else begin
                o_grant_valid = o_grant_valid;
            end
        end
    end

endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-granular Avalon-ST arbiter: locks one source from SOP to EOP and
// muxes it straight through to the merged output stream.
module ast_packet_arbiter
    import ast_arb_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int CHANNEL_WIDTH = 1,
    parameter  int NUM_SRC       = 2,
    localparam int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    localparam int ID_WIDTH      = $clog2(NUM_SRC)
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [NUM_SRC-1:0]                snk_valid_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     snk_data_i,
    input  logic [NUM_SRC-1:0]                snk_startofpacket_i,
    input  logic [NUM_SRC-1:0]                snk_endofpacket_i,
    input  logic [NUM_SRC*EMPTY_WIDTH-1:0]    snk_empty_i,
    input  logic [NUM_SRC*CHANNEL_WIDTH-1:0]  snk_channel_i,
    output logic [NUM_SRC-1:0]                snk_ready_o,
    output logic                              src_valid_o,
    output logic [DATA_WIDTH-1:0]             src_data_o,
    output logic                              src_startofpacket_o,
    output logic                              src_endofpacket_o,
    output logic [EMPTY_WIDTH-1:0]            src_empty_o,
    output logic [CHANNEL_WIDTH-1:0]          src_channel_o,
    input  logic                              src_ready_i,
    output logic [ID_WIDTH-1:0]               src_id_o,
    output logic                              busy_o
);

    if (!num_src_is_legal(NUM_SRC)) begin : g_num_src_check
        $error("ast_packet_arbiter: NUM_SRC must be within 2..8");
    end

    // Last winner resets to the top index so source 0 wins the first round.
    localparam logic [ID_WIDTH-1:0] LAST_GRANT_RST = ID_WIDTH'(NUM_SRC - 1);

    arb_state_e          r_state;
    logic [ID_WIDTH-1:0] r_gnt_idx;
    logic [NUM_SRC-1:0]  r_gnt_oh;
    logic [ID_WIDTH-1:0] r_last_grant;

    logic [NUM_SRC-1:0]  w_req;
    logic [NUM_SRC-1:0]  w_arb_grant;
    logic [ID_WIDTH-1:0] w_arb_idx;
    logic                w_arb_valid;
    logic                w_locked;
    logic                w_eop_xfer;

    // Only a valid beat flagged as SOP may open a new packet.
    assign w_req = snk_valid_i & snk_startofpacket_i;

    rr_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .i_req         (w_req),
        .i_last_grant  (r_last_grant),
        .o_grant       (w_arb_grant),
        .o_grant_idx   (w_arb_idx),
        .o_grant_valid (w_arb_valid)
    );

    assign w_locked   = (r_state == ST_LOCKED);
    assign w_eop_xfer = src_valid_o & src_ready_i & src_endofpacket_o;
    assign busy_o     = w_locked;
    assign src_id_o   = r_gnt_idx;

    // Arbitration FSM: register the pick in IDLE, release on a transferred EOP.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_gnt_idx    <= '0;
            r_gnt_oh     <= '0;
            r_last_grant <= LAST_GRANT_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_state   <= ST_LOCKED;
                        r_gnt_idx <= w_arb_idx;
                        r_gnt_oh  <= w_arb_grant;
                    end
                end
                ST_LOCKED: begin
                    if (w_eop_xfer) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= r_gnt_idx;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // AND-OR mux of the granted source; control strobes gated off outside a lock.
    always_comb begin
        src_data_o          = '0;
        src_empty_o         = '0;
        src_channel_o       = '0;
        src_valid_o         = 1'b0;
        src_startofpacket_o = 1'b0;
        src_endofpacket_o   = 1'b0;
        snk_ready_o         = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_data_o    = src_data_o
                          | ({DATA_WIDTH{r_gnt_oh[k]}} & snk_data_i[k*DATA_WIDTH +: DATA_WIDTH]);
            src_empty_o   = src_empty_o
                          | ({EMPTY_WIDTH{r_gnt_oh[k]}} & snk_empty_i[k*EMPTY_WIDTH +: EMPTY_WIDTH]);
            src_channel_o = src_channel_o
                          | ({CHANNEL_WIDTH{r_gnt_oh[k]}} & snk_channel_i[k*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
        end
        if (w_locked) begin
            src_valid_o         = |(r_gnt_oh & snk_valid_i);
            src_startofpacket_o = |(r_gnt_oh & snk_startofpacket_i);
            src_endofpacket_o   = |(r_gnt_oh & snk_endofpacket_i);
            snk_ready_o         = r_gnt_oh & {NUM_SRC{src_ready_i}};
        end else begin
            src_valid_o         = 1'b0;
            src_startofpacket_o = 1'b0;
            src_endofpacket_o   = 1'b0;
            snk_ready_o         = '0;
        end
    end

endmodule
